micron_burst_controller: RTL and testbench

- Second-generation controller for the Micron MT45W8 pseudo-SRAM in synchronous burst mode.
- Adds a registered bidirectional data path, programmable latency, variable burst length and mwait-driven stalls.
- Adds a configuration-register (CRE) write mode.
- Sits between the system bus (device-address handshake, bwait flow control) and the external memory pins.

---
 rtl/micron_burst_controller.sv | 193 +++++++++++++++++++
 tb/tb_micron_burst_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/micron_burst_controller.sv
// Burst controller for the MT45W8 pseudo-SRAM: bus read/write bursts and config-register writes.
// Latency: RW_LATENCY clocks from address cycle to first data word; read data reaches the bus one clock after capture.
// Backpressure: mwait stalls DATA cycles (bwait=1, no transfer); the bus holds its word while bwait is high.
//
// Ports: clk50MHz/rst_L clock and async active-low reset; baddr/bburst/bdata_in/bdata_out/bvalid/bwait system bus;
//        maddr/mdata_out/mdata_in/mdata_oe and active-low strobes to the memory; mclk gated memory clock;
//        mwait memory stall request.
module micron_burst_controller #(
    parameter int A_WIDTH    = 16,
    parameter int D_WIDTH    = 16,
    parameter int BURST_W    = 4,
    parameter int LAT_W      = 3,
    parameter int RW_LATENCY = 4,
    parameter logic [A_WIDTH-1:0] CTRL_ADDR_READ  = 16'hFFFA,
    parameter logic [A_WIDTH-1:0] CTRL_ADDR_WRITE = 16'hFFFB,
    parameter logic [A_WIDTH-1:0] CTRL_ADDR_CFG   = 16'hFFFC
) (
    input  logic               clk50MHz,
    input  logic               rst_L,
    input  logic [A_WIDTH-1:0] baddr,
    input  logic [BURST_W-1:0] bburst,
    input  logic [D_WIDTH-1:0] bdata_in,
    output logic [D_WIDTH-1:0] bdata_out,
    output logic               bvalid,
    output logic               bwait,
    output logic [A_WIDTH-1:0] maddr,
    output logic [D_WIDTH-1:0] mdata_out,
    input  logic [D_WIDTH-1:0] mdata_in,
    output logic               mdata_oe,
    output logic               moe_L,
    output logic               mwe_L,
    output logic               madv_L,
    output logic               mce_L,
    output logic               mcre,
    output logic               mub_L,
    output logic               mlb_L,
    output logic               mclk,
    input  logic               mwait
);

    typedef enum logic [2:0] {IDLE, ADDR, CFG, LATENCY, DATA, FINISH} state_t;
    typedef enum logic [1:0] {M_READ, M_WRITE, M_CFG} mode_t;

    // Last LATENCY count before DATA; unused when RW_LATENCY==1 skips LATENCY.
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RW_LATENCY - 2);

    state_t             state;
    mode_t              mode;
    logic [LAT_W-1:0]   lat_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_len;
    logic               bwait_q;
    logic               rd_vld_q;
    logic               mclk_en;

    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            mode      <= M_READ;
            lat_cnt   <= '0;
            burst_cnt <= '0;
            burst_len <= '0;
            bwait_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            bdata_out <= '0;
            maddr     <= '0;
            mdata_out <= '0;
            mdata_oe  <= 1'b0;
            mcre      <= 1'b0;
            moe_L     <= 1'b1;
            mwe_L     <= 1'b1;
            madv_L    <= 1'b1;
            mce_L     <= 1'b1;
        end else begin
            rd_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (baddr == CTRL_ADDR_READ || baddr == CTRL_ADDR_WRITE) begin
                        state   <= ADDR;
                        mode    <= (baddr == CTRL_ADDR_WRITE) ? M_WRITE : M_READ;
                        mce_L   <= 1'b0;
                        madv_L  <= 1'b0;
                        mwe_L   <= (baddr == CTRL_ADDR_WRITE) ? 1'b0 : 1'b1;
                        bwait_q <= 1'b1;
                    end else if (baddr == CTRL_ADDR_CFG) begin
                        state   <= CFG;
                        mode    <= M_CFG;
                        mcre    <= 1'b1;
                        mce_L   <= 1'b0;
                        madv_L  <= 1'b0;
                        mwe_L   <= 1'b0;
                        bwait_q <= 1'b1;
                        lat_cnt <= '0;
                    end
                end
                ADDR: begin
                    maddr     <= baddr;
                    burst_len <= bburst;
                    madv_L    <= 1'b1;
                    mwe_L     <= 1'b1;
                    lat_cnt   <= '0;
                    burst_cnt <= '0;
                    if (RW_LATENCY == 1) begin
                        state    <= DATA;
                        moe_L    <= (mode == M_READ) ? 1'b0 : 1'b1;
                        mdata_oe <= (mode == M_WRITE);
                        bwait_q  <= 1'b0;
                    end else begin
                        state <= LATENCY;
                    end
                end
                LATENCY: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAT_LAST) begin
                        state    <= DATA;
                        moe_L    <= (mode == M_READ) ? 1'b0 : 1'b1;
                        mdata_oe <= (mode == M_WRITE);
                        bwait_q  <= 1'b0;
                    end
                end
                DATA: begin
                    if (!mwait) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (mode == M_READ) begin
                            bdata_out <= mdata_in;
                            rd_vld_q  <= 1'b1;
                        end else begin
                            mdata_out <= bdata_in;
                        end
                        // Compare before the increment so a full 2^BURST_W burst ends on the last word.
                        if (burst_cnt == burst_len) begin
                            state    <= FINISH;
                            mce_L    <= 1'b1;
                            moe_L    <= 1'b1;
                            mdata_oe <= 1'b0;
                        end
                    end
                end
                CFG: begin
                    // Two fixed cycles: the CR value is on baddr during the first one.
                    if (lat_cnt == '0) begin
                        maddr   <= baddr;
                        lat_cnt <= lat_cnt + 1'b1;
                    end else begin
                        state   <= FINISH;
                        mcre    <= 1'b0;
                        mce_L   <= 1'b1;
                        madv_L  <= 1'b1;
                        mwe_L   <= 1'b1;
                        bwait_q <= 1'b0;
                        lat_cnt <= '0;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    lat_cnt   <= '0;
                    burst_cnt <= '0;
                    bwait_q   <= 1'b0;
                    mdata_oe  <= 1'b0;
                    moe_L     <= 1'b1;
                    mwe_L     <= 1'b1;
                    madv_L    <= 1'b1;
                    mce_L     <= 1'b1;
                    mcre      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clock enable changes only while clk50MHz is low, so the gated clock never glitches.
    // A config write is asynchronous to mclk, so its FINISH cycle keeps the clock parked.
    always_ff @(negedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            mclk_en <= 1'b0;
        end else begin
            mclk_en <= (state == LATENCY) || (state == DATA) ||
                       (state == FINISH && mode != M_CFG);
        end
    end

    assign mclk = clk50MHz & mclk_en;

    // Writes consume bdata_in in the transferring cycle; reads present the word one clock
    // after capture. A read word being delivered takes priority over a stall indication so
    // bvalid and bwait are never both high.
    assign bvalid = rd_vld_q | ((state == DATA) && (mode == M_WRITE) && !mwait);
    assign bwait  = bwait_q | ((state == DATA) && mwait && !bvalid);

    assign mub_L = 1'b0;
    assign mlb_L = 1'b0;

endmodule

// File: tb/tb_micron_burst_controller.sv
// Directed bench for micron_burst_controller: reset, read/write/config bursts, stalls, max burst, reset abort.
// Latency: defaults RW_LATENCY=4, so the first DATA cycle is the 5th cycle after the device address.
// Backpressure: the bus model holds bdata_in until it observes bvalid.
module tb_micron_burst_controller;

    localparam logic [15:0] RD  = 16'hFFFA;
    localparam logic [15:0] WR  = 16'hFFFB;
    localparam logic [15:0] CF  = 16'hFFFC;
    localparam logic [9:0]  IDLE_PINS = 10'b1111_0000_00;

    logic        clk50MHz = 1'b0;
    logic        rst_L;
    logic [15:0] baddr;
    logic [3:0]  bburst;
    logic [15:0] bdata_in;
    logic [15:0] bdata_out;
    logic        bvalid;
    logic        bwait;
    logic [15:0] maddr;
    logic [15:0] mdata_out;
    logic [15:0] mdata_in;
    logic        mdata_oe;
    logic        moe_L, mwe_L, madv_L, mce_L, mcre, mub_L, mlb_L, mclk;
    logic        mwait;

    always #10 clk50MHz = ~clk50MHz;

    micron_burst_controller dut (
        .clk50MHz (clk50MHz),
        .rst_L    (rst_L),
        .baddr    (baddr),
        .bburst   (bburst),
        .bdata_in (bdata_in),
        .bdata_out(bdata_out),
        .bvalid   (bvalid),
        .bwait    (bwait),
        .maddr    (maddr),
        .mdata_out(mdata_out),
        .mdata_in (mdata_in),
        .mdata_oe (mdata_oe),
        .moe_L    (moe_L),
        .mwe_L    (mwe_L),
        .madv_L   (madv_L),
        .mce_L    (mce_L),
        .mcre     (mcre),
        .mub_L    (mub_L),
        .mlb_L    (mlb_L),
        .mclk     (mclk),
        .mwait    (mwait)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered by drive_read.
    logic [15:0] seen [0:31];
    int          n_vld, n_adv, n_bw, n_both, n_mclk, first_vld;
    logic [15:0] maddr_c2;

    function automatic logic [9:0] pins();
        return {mce_L, madv_L, mwe_L, moe_L, mcre, mdata_oe, bwait, bvalid, mub_L, mlb_L};
    endfunction

    // Bus + memory stimulus for one read: device address in cycle 0, address/length in
    // cycle 1, memory words A0+i presented in cycles 5..5+len (first DATA cycle at latency 4).
    task automatic drive_read(input logic [15:0] a, input logic [3:0] len, input int ncyc);
        n_vld = 0; n_adv = 0; n_bw = 0; n_both = 0; n_mclk = 0; first_vld = -1;
        maddr_c2 = 16'h0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk50MHz); #1;
            if (mclk) n_mclk++;
            baddr    = (c == 0) ? RD : ((c == 1) ? a : 16'h0000);
            bburst   = (c == 1) ? len : 4'd0;
            mdata_in = (c >= 5 && c <= 5 + int'(len)) ? 16'h00A0 + 16'(c - 5) : 16'hDEAD;
            mwait    = 1'b0;
            @(negedge clk50MHz);
            if (!madv_L) n_adv++;
            if (bwait) n_bw++;
            if (bvalid && bwait) n_both++;
            if (c == 2) maddr_c2 = maddr;
            if (bvalid) begin
                if (n_vld < 32) seen[n_vld] = bdata_out;
                if (n_vld == 0) first_vld = c;
                n_vld++;
            end
        end
    endtask

    task automatic test_reset();
        rst_L = 1'b0; baddr = 16'h0; bburst = 4'd0; bdata_in = 16'h0; mdata_in = 16'h0; mwait = 1'b0;
        repeat (3) @(negedge clk50MHz);
        checks++;
        if (pins() !== IDLE_PINS) begin
            errors++; $display("FAIL reset_pins: got %b expected %b", pins(), IDLE_PINS);
        end
        checks++;
        if ({maddr, mdata_out, bdata_out} !== 48'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected 0 0 0", maddr, mdata_out, bdata_out);
        end
        rst_L = 1'b1;
        @(posedge clk50MHz); #1;
        checks++;
        if (mclk !== 1'b0) begin
            errors++; $display("FAIL reset_mclk: got %b expected 0", mclk);
        end
        @(negedge clk50MHz);
        checks++;
        if (pins() !== IDLE_PINS) begin
            errors++; $display("FAIL post_reset_idle: got %b expected %b", pins(), IDLE_PINS);
        end
    endtask

    task automatic test_read_burst();
        drive_read(16'h0100, 4'd3, 12);
        checks++;
        if (n_adv !== 1) begin errors++; $display("FAIL rd_adv_cycles: got %0d expected 1", n_adv); end
        checks++;
        if (n_bw !== 4) begin errors++; $display("FAIL rd_bwait_cycles: got %0d expected 4", n_bw); end
        checks++;
        if (n_vld !== 4) begin errors++; $display("FAIL rd_bvalid_count: got %0d expected 4", n_vld); end
        checks++;
        if (first_vld !== 6) begin errors++; $display("FAIL rd_first_valid_cycle: got %0d expected 6", first_vld); end
        checks++;
        if (maddr_c2 !== 16'h0100) begin errors++; $display("FAIL rd_maddr: got %h expected 0100", maddr_c2); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== 16'h00A0 + 16'(i)) begin
                errors++; $display("FAIL rd_word%0d: got %h expected %h", i, seen[i], 16'h00A0 + 16'(i));
            end
        end
        checks++;
        if (n_both !== 0) begin errors++; $display("FAIL rd_valid_and_wait: got %0d expected 0", n_both); end
        checks++;
        if (n_mclk !== 8) begin errors++; $display("FAIL rd_mclk_pulses: got %0d expected 8", n_mclk); end
        checks++;
        if (pins() !== IDLE_PINS) begin errors++; $display("FAIL rd_back_idle: got %b expected %b", pins(), IDLE_PINS); end
    endtask

    task automatic test_write_stall();
        int nv = 0, nwe = 0, nbw = 0;
        logic [15:0] out7 = 16'h0, out8 = 16'h0;
        logic bw5 = 1'b0, bv5 = 1'b1, oe5 = 1'b0, oe8 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk50MHz); #1;
            baddr    = (c == 0) ? WR : ((c == 1) ? 16'h0200 : 16'h0000);
            bburst   = (c == 1) ? 4'd1 : 4'd0;
            bdata_in = (nv == 0) ? 16'h5A01 : 16'h5A02;
            mwait    = (c == 5);
            @(negedge clk50MHz);
            if (bvalid) nv++;
            if (!mwe_L) nwe++;
            if (bwait) nbw++;
            if (c == 5) begin bw5 = bwait; bv5 = bvalid; oe5 = mdata_oe; end
            if (c == 7) out7 = mdata_out;
            if (c == 8) begin out8 = mdata_out; oe8 = mdata_oe; end
        end
        mwait = 1'b0;
        checks++;
        if (nwe !== 1) begin errors++; $display("FAIL wr_we_cycles: got %0d expected 1", nwe); end
        checks++;
        if ({bw5, bv5} !== 2'b10) begin errors++; $display("FAIL wr_stall_flags: got %b expected 10", {bw5, bv5}); end
        checks++;
        if (oe5 !== 1'b1) begin errors++; $display("FAIL wr_oe_data: got %b expected 1", oe5); end
        checks++;
        if (out7 !== 16'h5A01) begin errors++; $display("FAIL wr_word0: got %h expected 5a01", out7); end
        checks++;
        if (out8 !== 16'h5A02) begin errors++; $display("FAIL wr_word1: got %h expected 5a02", out8); end
        checks++;
        if (oe8 !== 1'b0) begin errors++; $display("FAIL wr_oe_finish: got %b expected 0", oe8); end
        checks++;
        if (nv !== 2) begin errors++; $display("FAIL wr_bvalid_count: got %0d expected 2", nv); end
        checks++;
        if (nbw !== 5) begin errors++; $display("FAIL wr_bwait_cycles: got %0d expected 5", nbw); end
    endtask

    // Config write; a read device address offered during FINISH must be ignored.
    task automatic test_config();
        int ncre = 0, nwe = 0, nmclk = 0, nce = 0;
        logic [15:0] ma2 = 16'h0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk50MHz); #1;
            if (mclk) nmclk++;
            baddr = (c == 0) ? CF : ((c <= 2) ? 16'h1D1F : ((c == 3) ? RD : 16'h0000));
            @(negedge clk50MHz);
            if (mcre) ncre++;
            if (!mwe_L) nwe++;
            if (c == 2) ma2 = maddr;
            if (c >= 4 && !mce_L) nce++;
        end
        checks++;
        if (ncre !== 2) begin errors++; $display("FAIL cfg_cre_cycles: got %0d expected 2", ncre); end
        checks++;
        if (nwe !== 2) begin errors++; $display("FAIL cfg_we_cycles: got %0d expected 2", nwe); end
        checks++;
        if (ma2 !== 16'h1D1F) begin errors++; $display("FAIL cfg_maddr: got %h expected 1d1f", ma2); end
        checks++;
        if (nmclk !== 0) begin errors++; $display("FAIL cfg_mclk: got %0d pulses expected 0", nmclk); end
        checks++;
        if (nce !== 0) begin errors++; $display("FAIL finish_addr_ignored: got %0d ce cycles expected 0", nce); end
        checks++;
        if (pins() !== IDLE_PINS) begin errors++; $display("FAIL cfg_back_idle: got %b expected %b", pins(), IDLE_PINS); end
    endtask

    task automatic test_max_burst();
        int nbad = 0;
        drive_read(16'h0300, 4'd15, 30);
        for (int i = 0; i < 16; i++) if (seen[i] !== 16'h00A0 + 16'(i)) nbad++;
        checks++;
        if (n_vld !== 16) begin errors++; $display("FAIL max_bvalid_count: got %0d expected 16", n_vld); end
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL max_data: got %0d bad words expected 0", nbad); end
        checks++;
        if (n_mclk !== 20) begin errors++; $display("FAIL max_mclk_pulses: got %0d expected 20", n_mclk); end
    endtask

    task automatic test_no_match();
        int nbad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk50MHz); #1;
            baddr = 16'h1234;
            @(negedge clk50MHz);
            if (mce_L !== 1'b1 || bwait !== 1'b0) nbad++;
        end
        baddr = 16'h0000;
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL no_match_idle: got %0d bad cycles expected 0", nbad); end
    endtask

    task automatic test_reset_mid_burst();
        drive_read(16'h0400, 4'd3, 7);
        @(posedge clk50MHz); #1;
        rst_L = 1'b0;
        #2;
        checks++;
        if (pins() !== IDLE_PINS) begin errors++; $display("FAIL abort_pins: got %b expected %b", pins(), IDLE_PINS); end
        checks++;
        if (mclk !== 1'b0) begin errors++; $display("FAIL abort_mclk: got %b expected 0", mclk); end
        checks++;
        if ({maddr, bdata_out} !== 32'h0) begin errors++; $display("FAIL abort_data: got %h %h expected 0 0", maddr, bdata_out); end
        @(negedge clk50MHz);
        rst_L = 1'b1;
        baddr = 16'h0000;
        @(negedge clk50MHz);
        checks++;
        if (pins() !== IDLE_PINS) begin errors++; $display("FAIL abort_idle: got %b expected %b", pins(), IDLE_PINS); end
        drive_read(16'h0500, 4'd0, 10);
        checks++;
        if (n_vld !== 1 || seen[0] !== 16'h00A0) begin
            errors++; $display("FAIL abort_recover: got %0d words first %h expected 1 00a0", n_vld, seen[0]);
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_stall();
        test_config();
        test_max_burst();
        test_no_match();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
